uint16_calc_arbiter: RTL and testbench
======================================

UINT16_CALC_ARBITER -- requirements
Module: uint16_calc_arbiter

Interface
REQ-001 The block SHALL have the parameter: LATENCY, 2, execute cycles per operation (legal range 1..15).
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 Port: req_ready  output  2  per-requester request accept.
REQ-006 Port: req_a  input  2x16  per-requester operand A (UInt16).
REQ-007 Port: req_b  input  2x16  per-requester operand B (UInt16).
REQ-008 Port: req_op  input  2x2  per-requester CalcOp (ADD=0, SUB=1, DIV=2, MUL=3).
REQ-009 Port: resp_valid  output  2  per-requester response valid; at most one bit set.
REQ-010 Port: resp_ready  input  2  per-requester response accept.
REQ-011 Port: resp_result  output  16  result for the requester whose resp_valid is set.
REQ-012 Port: resp_error  output  1  divide-by-zero flag qualified by resp_valid.
REQ-013 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL share one UInt16 calculator datapath between two requesters, one operation in flight at a time.
REQ-015 The FSM SHALL have states IDLE, EXEC, RESP; reset state IDLE.
REQ-016 In IDLE, req_ready SHALL be one-hot on the granted requester (combinational from req_valid and last_grant); zero in EXEC and RESP.
REQ-017 Grant: only one valid -> that one; both valid -> the requester not equal to last_grant.
REQ-018 On the IDLE cycle with req_valid[g] & req_ready[g], the block SHALL latch a, b, op, owner=g, set last_grant=g, load the cycle counter with LATENCY, and enter EXEC.
REQ-019 EXEC SHALL last exactly LATENCY cycles; on its final cycle the result and error SHALL be registered and the state SHALL move to RESP.
REQ-020 In RESP, resp_valid[owner] SHALL be 1 with resp_result/resp_error stable until resp_ready[owner]; on that handshake cycle the state SHALL return to IDLE.
REQ-021 resp_ready on the non-owner bit SHALL be ignored.
REQ-022 Arithmetic SHALL be modulo 2^16: ADD/SUB wrap, MUL keeps low 16 bits, DIV is unsigned truncating.
REQ-023 DIV with b=0 SHALL give resp_result=16'hFFFF, resp_error=1; all other cases resp_error=0.
REQ-024 A request arriving during EXEC/RESP SHALL wait (req_valid held by the requester); no request SHALL be dropped or duplicated.
REQ-025 Minimum throughput SHALL be one operation per LATENCY+2 cycles (no IDLE bypass).

Reset
REQ-026 While rst=1: state=IDLE, last_grant=1, counter=0, latched operands/result=0, req_ready=0, resp_valid=0, resp_result=0, resp_error=0, busy=0.
REQ-027 Reset mid-EXEC or mid-RESP SHALL abort the operation with no response issued.

Structure
REQ-028 CalcOp enum and UInt16 SHALL live in the shared types package; LATENCY stays a module parameter.
REQ-029 The datapath SHALL be one sub-module instance, uint16_calc_unit (combinational a/b/op -> result/error), sampled at end of EXEC.

Verification (LATENCY=2)
REQ-030 Req0 ADD 0xFFFF+0x0002, resp_ready=1 -> resp_valid[0] first high 3 cycles after accept, result 0x0001, error 0.
REQ-031 Both valid from reset, four ops each -> grants alternate 0,1,0,1,...; each response routed to its owner only.
REQ-032 Req1 DIV 0x1234/0x0000 -> result 0xFFFF, error 1; then DIV 0x1234/0x0010 -> 0x0123, error 0.
REQ-033 MUL 0x0100*0x0100 -> 0x0000; SUB 0x0003-0x0005 -> 0xFFFE.
REQ-034 resp_ready[0] low 5 cycles with req1 pending -> response held stable, req_ready=0, req1 accepted the cycle after handshake.
REQ-035 rst pulsed during EXEC -> all outputs at reset values asynchronously, no resp_valid afterward; next request served normally.

Source files
------------

// File: rtl/uint16_calc_arbiter_pkg.sv
// Shared types for the two-requester UInt16 calculator arbiter:
// operand type, operation codes, FSM states and the grant rule.
package uint16_calc_arbiter_pkg;

  typedef logic [15:0] uint16_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_DIV = 2'd2,
    OP_MUL = 2'd3
  } calc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam uint16_t DIV_ZERO_RESULT = 16'hFFFF;

  // A lone requester wins outright; on contention the one served less recently wins.
  function automatic logic pick_grant(input logic [1:0] valid, input logic last_grant);
    if (valid == 2'b11) return ~last_grant;
    return valid[1];
  endfunction

endpackage

// File: rtl/uint16_calc_unit.sv
// Combinational UInt16 calculator: wrapping add/sub/mul and unsigned
// truncating divide, with divide-by-zero reported through error.
module uint16_calc_unit
  import uint16_calc_arbiter_pkg::*;
(
  input  uint16_t  a,
  input  uint16_t  b,
  input  calc_op_e op,
  output uint16_t  result,
  output logic     error
);

  always_comb begin
    result = '0;
    error  = 1'b0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_MUL: result = a * b;
      OP_DIV: begin
        if (b == '0) begin
          result = DIV_ZERO_RESULT;
          error  = 1'b1;
        end else begin
          result = a / b;
        end
      end
    endcase
  end

endmodule

// File: rtl/uint16_calc_arbiter.sv
// Shares one uint16_calc_unit between two requesters: IDLE grants one
// request, EXEC waits LATENCY cycles, RESP holds the result for its owner.
module uint16_calc_arbiter
  import uint16_calc_arbiter_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][15:0] req_a,
  input  logic [1:0][15:0] req_b,
  input  logic [1:0][1:0]  req_op,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [15:0]      resp_result,
  output logic             resp_error,
  output logic             busy
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  state_e   state_q, state_d;
  logic     last_grant_q, last_grant_d;
  logic     owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  uint16_t  a_q, a_d;
  uint16_t  b_q, b_d;
  calc_op_e op_q, op_d;
  uint16_t  result_q, result_d;
  logic     error_q, error_d;

  logic     grant;
  logic     accept;
  logic     resp_done;
  logic     exec_last;
  uint16_t  calc_result;
  logic     calc_error;

  assign grant     = pick_grant(req_valid, last_grant_q);
  assign accept    = (state_q == ST_IDLE) && req_valid[grant];
  assign exec_last = (state_q == ST_EXEC) && (cnt_q == 4'd1);
  assign resp_done = (state_q == ST_RESP) && resp_ready[owner_q];

  uint16_calc_unit u_calc (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (calc_result),
    .error  (calc_error)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_EXEC;
      ST_EXEC: if (exec_last) state_d = ST_RESP;
      ST_RESP: if (resp_done) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Operands are captured at grant; the result is sampled on the last EXEC cycle.
  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    error_d      = error_q;
    if (accept) begin
      a_d          = req_a[grant];
      b_d          = req_b[grant];
      op_d         = calc_op_e'(req_op[grant]);
      owner_d      = grant;
      last_grant_d = grant;
      cnt_d        = LAT_LOAD;
    end
    if (state_q == ST_EXEC) begin
      cnt_d = cnt_q - 4'd1;
      if (exec_last) begin
        result_d = calc_result;
        error_d  = calc_error;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      result_q     <= '0;
      error_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      error_q      <= error_d;
    end
  end

  // req_ready is masked by rst because IDLE is also the state held during reset.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if ((state_q == ST_IDLE) && !rst) req_ready[grant] = req_valid[grant];
    if (state_q == ST_RESP)           resp_valid[owner_q] = 1'b1;
  end

  assign resp_result = result_q;
  assign resp_error  = error_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uint16_calc_arbiter.sv
// Self-checking bench for uint16_calc_arbiter (LATENCY=2): constant vectors,
// randomized traffic against a transaction-level model, and reset/stall corners.
module tb_uint16_calc_arbiter;
  import uint16_calc_arbiter_pkg::*;

  localparam int LAT = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][15:0] req_a;
  logic [1:0][15:0] req_b;
  logic [1:0][1:0]  req_op;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [15:0]      resp_result;
  logic             resp_error;
  logic             busy;

  always #5 clk = ~clk;

  uint16_calc_arbiter #(.LATENCY(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_error  (resp_error),
    .busy        (busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } op_t;

  typedef struct {
    bit          req;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_res;
    bit          exp_err;
  } vec_t;

  op_t q0[$];
  op_t q1[$];
  int  grant_log[$];

  // Transaction-level model of the arbiter.
  bit          m_inflight = 0;
  int          m_age = 0;
  bit          m_owner = 0;
  bit          m_last = 1;
  logic [15:0] m_res;
  bit          m_err;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          first_resp_cyc = -1;
  int          last_hs_cyc = -1;
  int          hold_cnt = 0;
  logic [15:0] obs_res;
  logic        obs_err;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void ref_calc(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output bit e);
    int unsigned ua;
    int unsigned ub;
    ua = a;
    ub = b;
    e  = 0;
    case (op)
      2'd0:    r = 16'((ua + ub) % 65536);
      2'd1:    r = 16'((ua + 65536 - ub) % 65536);
      2'd2:    if (ub == 0) begin r = 16'hFFFF; e = 1; end else r = 16'(ua / ub);
      default: r = 16'((ua * ub) % 65536);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    @(negedge clk);
    rst        = 1'b0;
    m_inflight = 0;
    m_last     = 1;
  endtask

  // mode 0: resp_ready always 1; mode 1: random; mode 2: owner 0 stalled 5 RESP cycles.
  task automatic apply_stimulus(input int mode, input int max_cycles);
    int          n;
    logic [1:0]  pend;
    logic [1:0]  exp_rdy;
    logic [1:0]  exp_rv;
    logic [1:0]  rr;
    bit          g;
    bit          resp_vis;
    op_t         h;
    n = 0;
    g = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_inflight) && n < max_cycles) begin
      @(negedge clk);
      n++;
      cyc++;
      pend      = {q1.size() != 0, q0.size() != 0};
      req_valid = pend;
      if (pend[0]) begin req_a[0] = q0[0].a; req_b[0] = q0[0].b; req_op[0] = q0[0].op; end
      if (pend[1]) begin req_a[1] = q1[0].a; req_b[1] = q1[0].b; req_op[1] = q1[0].op; end
      resp_vis = m_inflight && (m_age >= LAT + 1);
      case (mode)
        0: rr = 2'b11;
        1: rr = 2'($urandom);
        default: begin
          if (resp_vis && m_owner == 0 && hold_cnt < 5) begin
            rr = 2'b10;
            hold_cnt++;
          end else begin
            rr = 2'b11;
          end
        end
      endcase
      resp_ready = rr;
      #1;
      exp_rdy = '0;
      if (!m_inflight && pend != 0) begin
        g = (pend == 2'b11) ? !m_last : pend[1];
        exp_rdy[g] = 1'b1;
      end
      exp_rv = resp_vis ? (2'b01 << m_owner) : 2'b00;
      check_output("req_ready", req_ready, exp_rdy);
      check_output("resp_valid", resp_valid, exp_rv);
      check_output("busy", busy, m_inflight);
      if (resp_vis) begin
        check_output("resp_result", resp_result, m_res);
        check_output("resp_error", resp_error, m_err);
      end
      if (m_inflight && resp_valid[m_owner] && first_resp_cyc < 0) begin
        first_resp_cyc = cyc;
        obs_res        = resp_result;
        obs_err        = resp_error;
      end
      if (!m_inflight && pend != 0) begin
        if (g) h = q1.pop_front(); else h = q0.pop_front();
        ref_calc(h.op, h.a, h.b, m_res, m_err);
        if (mode == 2 && last_hs_cyc >= 0) check_output("accept_after_handshake", cyc - last_hs_cyc, 1);
        m_inflight     = 1;
        m_age          = 1;
        m_owner        = g;
        m_last         = g;
        acc_cyc        = cyc;
        first_resp_cyc = -1;
        grant_log.push_back(int'(g));
      end else if (m_inflight) begin
        if (resp_vis && rr[m_owner]) begin
          m_inflight  = 0;
          last_hs_cyc = cyc;
        end else if (!resp_vis) begin
          m_age++;
        end
      end
    end
    if (q0.size() != 0 || q1.size() != 0 || m_inflight) begin
      total++;
      bad++;
      $display("[TB] FAIL engine_timeout: work left after %0d cycles", n);
      q0.delete();
      q1.delete();
      m_inflight = 0;
    end
    @(posedge clk);
    #1;
    req_valid  = '0;
    resp_ready = '0;
  endtask

  vec_t vecs[10];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;

    vecs[0] = '{0, 2'd0, 16'hFFFF, 16'h0002, 16'h0001, 0};
    vecs[1] = '{1, 2'd2, 16'h1234, 16'h0000, 16'hFFFF, 1};
    vecs[2] = '{1, 2'd2, 16'h1234, 16'h0010, 16'h0123, 0};
    vecs[3] = '{0, 2'd3, 16'h0100, 16'h0100, 16'h0000, 0};
    vecs[4] = '{1, 2'd1, 16'h0003, 16'h0005, 16'hFFFE, 0};
    vecs[5] = '{0, 2'd3, 16'hFFFF, 16'hFFFF, 16'h0001, 0};
    vecs[6] = '{1, 2'd0, 16'h8000, 16'h8000, 16'h0000, 0};
    vecs[7] = '{0, 2'd2, 16'hFFFF, 16'h0001, 16'hFFFF, 0};
    vecs[8] = '{1, 2'd2, 16'h0005, 16'h0007, 16'h0000, 0};
    vecs[9] = '{0, 2'd1, 16'h0000, 16'h0001, 16'hFFFF, 0};

    #12;
    check_output("rst_req_ready", req_ready, 2'b00);
    check_output("rst_resp_valid", resp_valid, 2'b00);
    check_output("rst_busy", busy, 0);
    check_output("rst_resp_result", resp_result, 16'h0000);
    check_output("rst_resp_error", resp_error, 0);
    do_reset();

    // Owner 0 stalled with requester 1 waiting; bit 1 of resp_ready must be ignored.
    q0.push_back('{2'd0, 16'h0011, 16'h0022});
    q1.push_back('{2'd3, 16'h0003, 16'h0004});
    hold_cnt    = 0;
    last_hs_cyc = -1;
    apply_stimulus(2, 200);
    check_output("stall_cycles", hold_cnt, 5);

    foreach (vecs[i]) begin
      if (vecs[i].req) q1.push_back('{vecs[i].op, vecs[i].a, vecs[i].b});
      else             q0.push_back('{vecs[i].op, vecs[i].a, vecs[i].b});
      apply_stimulus(0, 100);
      check_output($sformatf("vec%0d_latency", i), first_resp_cyc - acc_cyc, LAT + 1);
      check_output($sformatf("vec%0d_result", i), obs_res, vecs[i].exp_res);
      check_output($sformatf("vec%0d_error", i), obs_err, vecs[i].exp_err);
    end

    // Both requesters contending from reset must alternate 0,1,0,1...
    do_reset();
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      q0.push_back('{2'($urandom), 16'($urandom), 16'($urandom)});
      q1.push_back('{2'($urandom), 16'($urandom), 16'($urandom)});
    end
    apply_stimulus(0, 200);
    check_output("grant_count", grant_log.size(), 8);
    foreach (grant_log[k]) check_output($sformatf("grant_order%0d", k), grant_log[k], k % 2);

    for (int k = 0; k < 30; k++) begin
      q0.push_back('{2'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 16'($urandom)});
      q1.push_back('{2'($urandom), 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom)});
    end
    apply_stimulus(1, 5000);

    // Asynchronous reset in the middle of EXEC aborts the operation.
    @(negedge clk);
    req_valid  = 2'b01;
    req_a[0]   = 16'h0001;
    req_b[0]   = 16'h0002;
    req_op[0]  = 2'd0;
    resp_ready = 2'b11;
    #1;
    check_output("abort_req_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    check_output("abort_busy_exec", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    check_output("abort_req_ready_rst", req_ready, 2'b00);
    check_output("abort_resp_valid_rst", resp_valid, 2'b00);
    check_output("abort_busy_rst", busy, 0);
    check_output("abort_result_rst", resp_result, 16'h0000);
    check_output("abort_error_rst", resp_error, 0);
    @(negedge clk);
    rst        = 1'b0;
    req_valid  = '0;
    m_inflight = 0;
    m_last     = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check_output("abort_no_resp", resp_valid, 2'b00);
    end
    q1.push_back('{2'd0, 16'h1000, 16'h0234});
    apply_stimulus(0, 100);
    check_output("after_abort_result", obs_res, 16'h1234);
    check_output("after_abort_latency", first_resp_cyc - acc_cyc, LAT + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
